// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic valid/ready pipeline register with optional skid entry,
// flush that zeroes held entries, and a saturating downstream-bubble counter.
module pipe_stage_skid #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int SKID = 1,
    parameter int BCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [BCNT_W-1:0] bubble_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} stateT;
    stateT state, stateNext;
    logic [CTRL_W-1:0] headCtrl, skidCtrl;
    logic [DATA_W-1:0] headData, skidData;
    logic accept, consume, loadHead, loadSkid, promote;

    // With the skid entry, in_ready decodes only the state register, so out_ready never reaches it
    assign out_valid = state != EMPTY;
    assign in_ready = (SKID != 0) ? (state != TWO) : (~out_valid | out_ready);
    assign accept = in_valid & in_ready;
    assign consume = out_valid & out_ready;
    assign occupancy = state;
    assign out_ctrl = out_valid ? headCtrl : '0;
    assign out_data = out_valid ? headData : '0;

    always_comb begin
        stateNext = state;
        loadHead = 1'b0;
        loadSkid = 1'b0;
        promote = 1'b0;
        case (state)
            EMPTY: begin
                loadHead = accept;
                stateNext = accept ? ONE : EMPTY;
            end
            ONE: begin
                loadHead = accept & consume;
                loadSkid = accept & ~consume;
                stateNext = loadSkid ? TWO : (consume & ~accept) ? EMPTY : ONE;
            end
            TWO: begin
                promote = consume;
                stateNext = consume ? ONE : TWO;
            end
            default: stateNext = EMPTY;
        endcase
        if (flush) stateNext = EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else state <= stateNext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            {headCtrl, headData} <= '0;
            {skidCtrl, skidData} <= '0;
        end else begin
            if (loadHead) {headCtrl, headData} <= {in_ctrl, in_data};
            else if (promote) {headCtrl, headData} <= {skidCtrl, skidData};
            if (loadSkid) {skidCtrl, skidData} <= {in_ctrl, in_data};
            else if (promote) {skidCtrl, skidData} <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bubble_cnt <= '0;
        else if (out_ready && !out_valid && !flush && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + BCNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: vector table, corner sequences and random traffic checked against a queue model
// for three instances: default skid, SKID=0, and a 3-bit bubble counter.
module tb_pipe_stage_skid;
    logic clk = 1'b0, reset = 1'b1, flush = 1'b0, inValid = 1'b0, outReady = 1'b0;
    logic [15:0] inCtrl = '0;
    logic [95:0] inData = '0;
    logic oValid [3];
    logic iReady [3];
    logic [15:0] oCtrl [3];
    logic [95:0] oData [3];
    logic [1:0] occ [3];
    logic [15:0] bcA, bcB;
    logic [2:0] bcC;
    int checks = 0, errors = 0;
    logic [111:0] mq [3][$];
    int mb [3] = '{0, 0, 0};
    int bmax [3] = '{65535, 65535, 7};

    typedef struct {
        logic v; logic [15:0] c; logic [95:0] d; logic r; logic f;
        logic eValid; logic [15:0] eCtrl; logic [95:0] eData; logic [1:0] eOcc; logic eReady;
    } vecT;
    vecT tbl [13];

    always #5 clk = ~clk;

    pipe_stage_skid dutA (.clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(iReady[0]),
        .in_ctrl(inCtrl), .in_data(inData), .out_valid(oValid[0]), .out_ready(outReady), .out_ctrl(oCtrl[0]),
        .out_data(oData[0]), .occupancy(occ[0]), .bubble_cnt(bcA));
    pipe_stage_skid #(.SKID(0)) dutB (.clk(clk), .reset(reset), .flush(flush), .in_valid(inValid),
        .in_ready(iReady[1]), .in_ctrl(inCtrl), .in_data(inData), .out_valid(oValid[1]), .out_ready(outReady),
        .out_ctrl(oCtrl[1]), .out_data(oData[1]), .occupancy(occ[1]), .bubble_cnt(bcB));
    pipe_stage_skid #(.BCNT_W(3)) dutC (.clk(clk), .reset(reset), .flush(flush), .in_valid(inValid),
        .in_ready(iReady[2]), .in_ctrl(inCtrl), .in_data(inData), .out_valid(oValid[2]), .out_ready(outReady),
        .out_ctrl(oCtrl[2]), .out_data(oData[2]), .occupancy(occ[2]), .bubble_cnt(bcC));

    function automatic logic [15:0] bcOf(input int k);
        return (k == 0) ? bcA : (k == 1) ? bcB : {13'd0, bcC};
    endfunction

    // Model readiness: skid instances take input until two entries are held; SKID=0 only when it drains
    function automatic logic mReady(input int k);
        int n = mq[k].size();
        return (k == 1) ? (n == 0 || outReady) : (n < 2);
    endfunction

    task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < 3; k++) begin
            int n = mq[k].size();
            logic [111:0] head = (n > 0) ? mq[k][0] : '0;
            string p = $sformatf("dut%0d ", k);
            chk({p, "out_valid"}, 112'(oValid[k]), 112'(n > 0));
            chk({p, "out_ctrl"}, 112'(oCtrl[k]), 112'(head[111:96]));
            chk({p, "out_data"}, 112'(oData[k]), 112'(head[95:0]));
            chk({p, "occupancy"}, 112'(occ[k]), 112'(n));
            chk({p, "in_ready"}, 112'(iReady[k]), 112'(mReady(k)));
            chk({p, "bubble_cnt"}, 112'(bcOf(k)), 112'(mb[k]));
        end
    endtask

    task automatic step(input logic v, input logic [15:0] c, input logic [95:0] d, input logic r, input logic f);
        @(negedge clk);
        inValid = v; inCtrl = c; inData = d; outReady = r; flush = f;
        #1 checkAll();
        for (int k = 0; k < 3; k++) begin
            int n = mq[k].size();
            logic acc = v && mReady(k);
            if (r && n == 0 && !f && mb[k] < bmax[k]) mb[k]++;
            if (f) mq[k].delete();
            else begin
                if (n > 0 && r) void'(mq[k].pop_front());
                if (acc) mq[k].push_back({c, d});
            end
        end
        @(posedge clk);
    endtask

    task automatic doReset();
        #2 inValid = 1'b0; outReady = 1'b0; flush = 1'b0; reset = 1'b1;
        #1 chk("reset out_valid", 112'(oValid[0]), 112'(0));
        chk("reset out_ctrl", 112'(oCtrl[0]), 112'(0));
        chk("reset out_data", 112'(oData[0]), 112'(0));
        chk("reset occupancy", 112'(occ[0]), 112'(0));
        chk("reset bubble_cnt", 112'(bcA), 112'(0));
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            mb[k] = 0;
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1 for (int k = 0; k < 3; k++) chk($sformatf("dut%0d in_ready after reset", k), 112'(iReady[k]), 112'(1));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'hC011, 96'h11, 1'b0, 1'b0, 1'b1, 16'hC011, 96'h11, 2'd1, 1'b1};
        tbl[1]  = '{1'b1, 16'hC022, 96'h22, 1'b0, 1'b0, 1'b1, 16'hC011, 96'h11, 2'd2, 1'b0};
        tbl[2]  = '{1'b1, 16'hC099, 96'h99, 1'b0, 1'b0, 1'b1, 16'hC011, 96'h11, 2'd2, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 96'h00, 1'b1, 1'b0, 1'b1, 16'hC022, 96'h22, 2'd1, 1'b1};
        tbl[4]  = '{1'b0, 16'h0000, 96'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 96'h00, 2'd0, 1'b1};
        tbl[5]  = '{1'b1, 16'hC044, 96'h44, 1'b0, 1'b0, 1'b1, 16'hC044, 96'h44, 2'd1, 1'b1};
        tbl[6]  = '{1'b1, 16'hC055, 96'h55, 1'b0, 1'b0, 1'b1, 16'hC044, 96'h44, 2'd2, 1'b0};
        tbl[7]  = '{1'b1, 16'hC033, 96'h33, 1'b1, 1'b1, 1'b0, 16'h0000, 96'h00, 2'd0, 1'b1};
        tbl[8]  = '{1'b0, 16'h0000, 96'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 96'h00, 2'd0, 1'b1};
        tbl[9]  = '{1'b1, 16'hC066, 96'h66, 1'b1, 1'b0, 1'b1, 16'hC066, 96'h66, 2'd1, 1'b1};
        tbl[10] = '{1'b1, 16'hC077, 96'h77, 1'b1, 1'b0, 1'b1, 16'hC077, 96'h77, 2'd1, 1'b1};
        tbl[11] = '{1'b0, 16'h0000, 96'h00, 1'b0, 1'b0, 1'b1, 16'hC077, 96'h77, 2'd1, 1'b1};
        tbl[12] = '{1'b0, 16'h0000, 96'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 96'h00, 2'd0, 1'b1};
        doReset();
        checkAll();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].r, tbl[i].f);
            #1 chk($sformatf("vec%0d out_valid", i), 112'(oValid[0]), 112'(tbl[i].eValid));
            chk($sformatf("vec%0d out_ctrl", i), 112'(oCtrl[0]), 112'(tbl[i].eCtrl));
            chk($sformatf("vec%0d out_data", i), 112'(oData[0]), 112'(tbl[i].eData));
            chk($sformatf("vec%0d occupancy", i), 112'(occ[0]), 112'(tbl[i].eOcc));
            chk($sformatf("vec%0d in_ready", i), 112'(iReady[0]), 112'(tbl[i].eReady));
        end
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 16'(i), 96'(i), 1'b1, 1'b0);
            #1 chk($sformatf("stream%0d out_data", i), 112'(oData[0]), 112'(i));
            chk($sformatf("stream%0d in_ready", i), 112'(iReady[0]), 112'(1));
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'(100 + i), 96'(100 + i), (i % 2 == 0), 1'b0);
            #1 chk($sformatf("skid0 occupancy<=1 at %0d", i), 112'(occ[1] > 2'd1), 112'(0));
        end
        step(1'b1, 16'hAAAA, 96'hA1, 1'b0, 1'b0);
        step(1'b1, 16'hBBBB, 96'hB2, 1'b0, 1'b0);
        #1 chk("prefill occupancy", 112'(occ[0]), 112'(2));
        doReset();
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 16'h0, 96'h0, 1'b1, 1'b0);
            #1 chk($sformatf("bubble3 cycle%0d", i), 112'(bcC), 112'((i < 7) ? i : 7));
            chk($sformatf("bubble16 cycle%0d", i), 112'(bcA), 112'(i));
        end
        step(1'b0, 16'h0, 96'h0, 1'b1, 1'b1);
        #1 chk("bubble flush hold16", 112'(bcA), 112'(10));
        chk("bubble flush hold3", 112'(bcC), 112'(7));
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(1)), 16'($urandom()), {$urandom(), $urandom(), $urandom()},
                 1'($urandom_range(3) != 0), 1'($urandom_range(15) == 0));
        @(negedge clk);
        #1 checkAll();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised elastic pipeline-stage register, successor to the fixed ID/EX latch.
- Carries a CTRL_W-bit control bundle and a DATA_W-bit datapath bundle between two stages.
- Uses a valid/ready handshake, an optional two-entry skid buffer for full throughput under backpressure, flush with guaranteed control zeroing, and a bubble counter for performance analysis.
- Instantiated between any pair of CPU pipeline stages (ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 96: width of datapath bundle (operands, immediate, PC+8).
- CTRL_W, 16: width of control bundle (RegDst, MemtoReg, MemWrite, ALUOp, RegWrite, class flags).
- SKID, 1: 1 = two-entry skid buffer, in_ready registered; 0 = single entry, in_ready combinational.
- BCNT_W, 16: width of saturating bubble counter.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous kill of all held entries, active-high.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept this cycle.
- in_ctrl, input, CTRL_W: upstream control bundle.
- in_data, input, DATA_W: upstream datapath bundle.
- out_valid, output, 1: head entry valid.
- out_ready, input, 1: downstream consumes the head this cycle.
- out_ctrl, output, CTRL_W: head control bundle; forced 0 when out_valid=0.
- out_data, output, DATA_W: head datapath bundle; forced 0 when out_valid=0.
- occupancy, output, 2: entries held (0..2).
- bubble_cnt, output, BCNT_W: saturating count of downstream bubble cycles.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, bubble_cnt=0.
  - Skid entry is invalid and zeroed.
  - in_ready=1 once reset deasserts.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
  - Payload must not be sampled unless its valid is high.
- Latency: an accepted entry reaches out_* on the next rising edge when the stage was empty, or was one-full and consumed in the same cycle.
- States (SKID=1), named by occupancy:
  - EMPTY (0):
    - Accept → ONE; head loads input.
  - ONE (1):
    - Accept & consume → ONE; head loads input.
    - Accept & ~consume → TWO; skid loads input.
    - ~accept & consume → EMPTY.
    - Otherwise hold.
  - TWO (2):
    - in_ready=0.
    - Consume → ONE; head takes skid; skid cleared.
    - Otherwise hold.
  - in_ready = (occupancy != 2), a register output with no combinational path from out_ready.
- SKID=0:
  - Only EMPTY and ONE exist; occupancy never reaches 2.
  - in_ready = ~out_valid | out_ready (combinational).
- Flush:
  - Has priority over accept and consume.
  - Next state is EMPTY; head and skid are invalidated and zeroed.
  - An input accepted in the flush cycle is discarded. Upstream still treats it as consumed.
  - A head consumed in the flush cycle counts as delivered.
- Hold: with out_valid=1 and out_ready=0, out_ctrl/out_data must be stable cycle to cycle.
- Ordering: strict FIFO; no entry is duplicated or dropped except by flush.
- bubble_cnt:
  - Increments on each cycle with out_ready=1, out_valid=0, flush=0.
  - Saturates at 2^BCNT_W−1.
  - Cleared only by reset.

Test Plan:
- Reset mid-stream: occupancy=2, assert reset asynchronously between edges → out_valid, out_ctrl, out_data, occupancy, bubble_cnt read 0 immediately; in_ready=1 after release.
- Streaming: SKID=1, in_valid=1 and out_ready=1 every cycle, in_data=1,2,3,…,20 → out_data 1..20 on consecutive cycles starting one edge after first accept; in_ready never 0.
- Backpressure:
  - Send A=0x11, B=0x22 with out_ready=0 → occupancy=2, in_ready=0, out_data=0x11 held.
  - Then out_ready=1 → outputs 0x11, then 0x22; occupancy steps 2→1→0.
- Flush at TWO with simultaneous in_valid=1 (data 0x33) → next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0; 0x33 never appears at output.
- SKID=0 with out_ready toggling 1,0,1,0 → in_ready equals ~out_valid|out_ready each cycle; occupancy ≤1; order preserved.
- Bubble counter: BCNT_W=3, empty stage, out_ready=1 for 10 cycles → bubble_cnt reads 1..7 then holds 7; a flush cycle does not increment it.
